// File: rtl/seq_pattern_tx.sv
// ---------------------------------------------------------------------------
// seq_pattern_tx
//
// Serialises a programmable bit pattern MSB-first, repeated a programmable
// number of times, for driving the serial input of a sequence detector.
//
// A start request seen in IDLE with a legal length (1..8) captures pattern,
// len and reps. The first bit appears on q in the very next cycle.
// Repetitions follow each other with no gap. After the last bit the FSM
// spends one cycle in DONE (done=1) and then returns to IDLE. A start with
// an illegal length (0 or >8) goes straight to DONE and sends no bits.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous reset, active low; has priority over start
//   start      in   1  transfer request, sampled only in IDLE
//   pattern    in   8  bits to send, captured on an accepted start
//   len        in   4  pattern length in bits (legal 1..8)
//   reps       in   4  repetition count (0 is treated as 1)
//   q          out  1  registered serial data, 0 when no bit is carried
//   bit_valid  out  1  high in every cycle that q carries a pattern bit
//   busy       out  1  high in SHIFT and DONE
//   done       out  1  single-cycle completion pulse (DONE state)
//   pst        out  2  present state (registered)
//   nst        out  2  next state (combinational)
// ---------------------------------------------------------------------------
module seq_pattern_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] pattern,
    input  logic [3:0] len,
    input  logic [3:0] reps,
    output logic       q,
    output logic       bit_valid,
    output logic       busy,
    output logic       done,
    output logic [1:0] pst,
    output logic [1:0] nst
);

    // Encoding is visible on pst/nst, so it is fixed explicitly.
    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StShift   = 2'b01,
        StDone    = 2'b10,
        StIllegal = 2'b11
    } state_e;

    // ------------------------------------------------------------------
    // State and captured transfer parameters
    // ------------------------------------------------------------------
    state_e     r_state;
    logic [7:0] r_pat;       // captured pattern
    logic [2:0] r_last_idx;  // captured len-1: index of the first (MSB) bit
    logic [2:0] r_idx;       // index of the bit currently on q
    logic [3:0] r_rep;       // repetitions remaining, including the current one
    logic       r_q;
    logic       r_bv;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_e     w_state_nxt;
    logic [7:0] w_pat_nxt;
    logic [2:0] w_last_idx_nxt;
    logic [2:0] w_idx_nxt;
    logic [3:0] w_rep_nxt;
    logic       w_q_nxt;
    logic       w_bv_nxt;

    logic       w_len_ok;
    logic [2:0] w_len_m1;
    logic [2:0] w_idx_dec;
    logic [3:0] w_reps_eff;

    assign w_len_ok   = (len != 4'd0) && (len <= 4'd8);
    // Only meaningful when w_len_ok; len-1 then always fits in 3 bits.
    assign w_len_m1   = 3'(len - 4'd1);
    assign w_idx_dec  = r_idx - 3'd1;
    assign w_reps_eff = (reps == 4'd0) ? 4'd1 : reps;

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_pat_nxt      = r_pat;
        w_last_idx_nxt = r_last_idx;
        w_idx_nxt      = r_idx;
        w_rep_nxt      = r_rep;
        w_q_nxt        = 1'b0;
        w_bv_nxt       = 1'b0;

        case (r_state)
            StIdle: begin
                if (start) begin
                    if (w_len_ok) begin
                        w_state_nxt    = StShift;
                        w_pat_nxt      = pattern;
                        w_last_idx_nxt = w_len_m1;
                        w_idx_nxt      = w_len_m1;
                        w_rep_nxt      = w_reps_eff;
                        // First bit is loaded at the accepting edge so it is
                        // on q in the cycle right after it.
                        w_q_nxt        = pattern[w_len_m1];
                        w_bv_nxt       = 1'b1;
                    end else begin
                        w_state_nxt = StDone;
                    end
                end
            end

            StShift: begin
                if (r_idx != 3'd0) begin
                    w_idx_nxt = w_idx_dec;
                    w_q_nxt   = r_pat[w_idx_dec];
                    w_bv_nxt  = 1'b1;
                end else if (r_rep > 4'd1) begin
                    // Restart at the MSB with no idle cycle in between.
                    w_rep_nxt = r_rep - 4'd1;
                    w_idx_nxt = r_last_idx;
                    w_q_nxt   = r_pat[r_last_idx];
                    w_bv_nxt  = 1'b1;
                end else begin
                    w_state_nxt = StDone;
                end
            end

            StDone: begin
                w_state_nxt = StIdle;
            end

            default: begin
                // Unused encoding recovers to IDLE.
                w_state_nxt = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register with synchronous active-low reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_pat      <= 8'd0;
            r_last_idx <= 3'd0;
            r_idx      <= 3'd0;
            r_rep      <= 4'd0;
            r_q        <= 1'b0;
            r_bv       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pat      <= w_pat_nxt;
            r_last_idx <= w_last_idx_nxt;
            r_idx      <= w_idx_nxt;
            r_rep      <= w_rep_nxt;
            r_q        <= w_q_nxt;
            r_bv       <= w_bv_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign q         = r_q;
    assign bit_valid = r_bv;
    assign busy      = (r_state == StShift) || (r_state == StDone);
    assign done      = (r_state == StDone);
    assign pst       = r_state;
    assign nst       = w_state_nxt;

endmodule
